// File: rtl/crc_frame_chk_pkg.sv
// Shared types and the generic CRC step for the frame checker.
// The step runs on max-width vectors so one function serves every CRC_W/DATA_W pairing.
package crc_frame_chk_pkg;

    typedef enum logic {
        StIdle    = 1'b0,
        StInFrame = 1'b1
    } crc_fsm_t;

    localparam int unsigned CrcMaxW  = 32;
    localparam int unsigned DataMaxW = 64;

    // Non-reflected, MSB-first update; bits above crc_w are kept at zero.
    function automatic logic [CrcMaxW-1:0] crc_step(
        input logic [CrcMaxW-1:0]  crc,
        input logic [DataMaxW-1:0] data,
        input logic [CrcMaxW-1:0]  poly,
        input int unsigned         crc_w,
        input int unsigned         data_w
    );
        logic [CrcMaxW-1:0] c;
        logic [CrcMaxW-1:0] mask;
        logic [4:0]         msb;
        logic               fb;
        mask = '1;
        mask = mask >> (CrcMaxW - crc_w);
        msb  = 5'(crc_w - 1);
        c    = crc & mask;
        fb   = 1'b0;
        for (int i = DataMaxW - 1; i >= 0; i--) begin
            if (i < int'(data_w)) begin
                fb = c[msb] ^ data[6'(i)];
                c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_frame_chk_crc_upd.sv
// Combinational one-beat CRC update: folds DATA_W bits of data into the running CRC.
import crc_frame_chk_pkg::*;

module crc_frame_chk_crc_upd #(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'('h07)
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CrcMaxW-1:0] crc_full;
    logic               unused_hi;

    assign crc_full  = crc_step(CrcMaxW'(crc_i), DataMaxW'(data_i), CrcMaxW'(POLY), CRC_W, DATA_W);
    assign crc_o     = crc_full[CRC_W-1:0];
    // The step masks to CRC_W, so the upper bits are always zero.
    assign unused_hi = ^(crc_full >> CRC_W);

endmodule

// File: rtl/crc_frame_chk.sv
// Streaming multi-beat CRC checker with a 1-stage valid/ready forwarding register,
// per-frame verdict on the eop beat, sticky error flag and saturating error count.
import crc_frame_chk_pkg::*;

module crc_frame_chk #(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'('h07),
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter logic [CRC_W-1:0] XOR_OUT   = '0,
    parameter int unsigned      ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [CRC_W-1:0]     in_crc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 out_crc_err,
    output logic                 prot_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr
);

    crc_fsm_t             state_q, state_d;
    logic [CRC_W-1:0]     crc_q, crc_d, crc_base, crc_next;
    logic                 accept, frame_beat, check_eop, mismatch, prot_viol;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic                 out_crc_err_q, out_crc_err_d;
    logic                 prot_err_q, prot_err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign in_ready = out_ready || !out_valid_q;
    assign accept   = in_valid && in_ready;

    crc_frame_chk_crc_upd #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_crc_upd (
        .crc_i  (crc_base),
        .data_i (in_data),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_sop) begin
                state_d = in_eop ? StIdle : StInFrame;
            end else if (in_eop) begin
                state_d = StIdle;
            end
        end
    end

    // A sop always restarts from INIT, even when it cuts an open frame short.
    always_comb begin
        frame_beat = in_sop || (state_q == StInFrame);
        crc_base   = in_sop ? INIT : crc_q;
        check_eop  = accept && frame_beat && in_eop;
        prot_viol  = accept && (in_sop ? (state_q == StInFrame) : (state_q == StIdle));
        mismatch   = check_eop && ((crc_next ^ XOR_OUT) != in_crc);
    end

    always_comb begin
        crc_d         = crc_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_crc_err_d = out_crc_err_q;
        prot_err_d    = prot_viol;
        err_sticky_d  = err_sticky_q;
        err_cnt_d     = err_cnt_q;

        if (accept && frame_beat) begin
            crc_d = crc_next;
        end

        if (accept) begin
            out_valid_d   = 1'b1;
            out_data_d    = in_data;
            out_sop_d     = in_sop;
            out_eop_d     = in_eop;
            out_crc_err_d = mismatch;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end

        // Clear first so a same-cycle mismatch still lands on top of it.
        if (clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
        if (mismatch) begin
            err_sticky_d = 1'b1;
            if (!(&err_cnt_d)) begin
                err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q         <= INIT;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_crc_err_q <= 1'b0;
            prot_err_q    <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            crc_q         <= crc_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_crc_err_q <= out_crc_err_d;
            prot_err_q    <= prot_err_d;
            err_sticky_q  <= err_sticky_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_crc_err = out_crc_err_q;
    assign prot_err    = prot_err_q;
    assign err_sticky  = err_sticky_q;
    assign err_cnt     = err_cnt_q;

endmodule
